// File: rtl/dram_bist_if.sv
// Sequencer <-> RAM/host bundle for the DRAM march-test sequencer.
// master is the sequencer side, slave is the RAM/LED/host side.
interface dram_bist_if;
    logic       start;
    logic [4:0] dram_addr;
    logic [7:0] dram_di;
    logic       dram_we;
    logic [7:0] dram_do;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [7:0] err_mask;
    logic [4:0] first_err_addr;
    logic       first_err_valid;

    modport master (
        input  start, dram_do,
        output dram_addr, dram_di, dram_we, busy, done, pass,
               err_count, err_mask, first_err_addr, first_err_valid
    );

    modport slave (
        output start, dram_do,
        input  dram_addr, dram_di, dram_we, busy, done, pass,
               err_count, err_mask, first_err_addr, first_err_valid
    );
endinterface

// File: rtl/dram_bist_seq.sv
// March-test sequencer for a 32x8 quad-port distributed RAM: W0 up, (R0,W1) up,
// R1 down, with sticky error diagnostics for board LEDs.
module dram_bist_seq #(
    parameter logic [7:0] BG = 8'hA5
) (
    input  logic      clk,
    input  logic      rst,
    dram_bist_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_R0   = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_R1   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0] state;
    logic [4:0] addr;
    logic [6:0] err_count;
    logic [7:0] err_mask;
    logic [4:0] first_err_addr;
    logic       first_err_valid;

    logic       launch;
    logic       is_read;
    logic [7:0] expected;
    logic [7:0] diff;
    logic       mismatch;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        launch   = (state == S_IDLE || state == S_DONE) && bus.start;
        is_read  = (state == S_R0) || (state == S_R1);
        expected = (state == S_R1) ? ~BG : BG;
        diff     = bus.dram_do ^ expected;
        mismatch = is_read && (diff != 8'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            addr  <= 5'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state <= S_W0;
                        addr  <= 5'd0;
                    end
                end
                S_W0: begin
                    if (addr == 5'd31) begin
                        state <= S_R0;
                        addr  <= 5'd0;
                    end else begin
                        addr <= addr + 5'd1;
                    end
                end
                S_R0: state <= S_W1;
                S_W1: begin
                    // R1 starts at the top address, so the counter is not advanced past 31
                    if (addr == 5'd31) begin
                        state <= S_R1;
                    end else begin
                        state <= S_R0;
                        addr  <= addr + 5'd1;
                    end
                end
                S_R1: begin
                    if (addr == 5'd0) state <= S_DONE;
                    else              addr  <= addr - 5'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count       <= 7'd0;
            err_mask        <= 8'd0;
            first_err_addr  <= 5'd0;
            first_err_valid <= 1'b0;
        end else if (launch) begin
            err_count       <= 7'd0;
            err_mask        <= 8'd0;
            first_err_addr  <= 5'd0;
            first_err_valid <= 1'b0;
        end else if (mismatch) begin
            if (err_count != 7'd127) err_count <= err_count + 7'd1;
            err_mask <= err_mask | diff;
            if (!first_err_valid) begin
                first_err_addr  <= addr;
                first_err_valid <= 1'b1;
            end
        end
    end

    // Outputs decode registers only; write enable follows the async-reset state register
    assign bus.dram_addr       = addr;
    assign bus.dram_we         = (state == S_W0) || (state == S_W1);
    assign bus.dram_di         = (state == S_W0) ? BG : (state == S_W1) ? ~BG : 8'd0;
    assign bus.busy            = (state == S_W0) || (state == S_R0) ||
                                 (state == S_W1) || (state == S_R1);
    assign bus.done            = (state == S_DONE);
    assign bus.pass            = (state == S_DONE) && (err_count == 7'd0);
    assign bus.err_count       = err_count;
    assign bus.err_mask        = err_mask;
    assign bus.first_err_addr  = first_err_addr;
    assign bus.first_err_valid = first_err_valid;
endmodule

// File: tb/tb_dram_bist_seq.sv
// Self-checking bench for dram_bist_seq: behavioural 32x8 RAM with injectable faults
// and a march-test reference model that predicts every cycle and the final diagnostics.
module tb_dram_bist_seq;
    localparam logic [7:0] BG = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dram_bist_if bus ();

    dram_bist_seq #(.BG(BG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Fault configuration for the RAM model.
    logic       alias_en   = 1'b0;
    logic       stuck_en   = 1'b0;
    logic [4:0] stuck_addr = 5'd0;
    logic [2:0] stuck_bit  = 3'd0;
    logic       stuck_val  = 1'b0;

    function automatic logic [4:0] map_addr(input logic [4:0] a, input logic al);
        return al ? {1'b0, a[3:0]} : a;
    endfunction

    function automatic logic [7:0] rd_fault(input logic [7:0] d, input logic [4:0] a,
                                            input logic en, input logic [4:0] fa,
                                            input logic [2:0] fb, input logic fv);
        logic [7:0] r;
        r = d;
        if (en && a == fa) r[fb] = fv;
        return r;
    endfunction

    logic [7:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 8'd0;

    always @(posedge clk) if (bus.dram_we === 1'b1) mem[map_addr(bus.dram_addr, alias_en)] <= bus.dram_di;

    assign bus.dram_do = rd_fault(mem[map_addr(bus.dram_addr, alias_en)], bus.dram_addr,
                                  stuck_en, stuck_addr, stuck_bit, stuck_val);

    // Reference model results.
    logic [4:0] q_addr [$];
    logic       q_we   [$];
    logic [7:0] q_di   [$];
    int         m_cnt;
    logic [7:0] m_mask;
    logic [4:0] m_faddr;
    logic       m_fvalid;

    task automatic model_cmp(input logic [4:0] a, input logic [7:0] got, input logic [7:0] exp);
        if (got != exp) begin
            if (m_cnt < 127) m_cnt++;
            m_mask = m_mask | (got ^ exp);
            if (!m_fvalid) begin
                m_faddr  = a;
                m_fvalid = 1'b1;
            end
        end
    endtask

    task automatic model_run();
        logic [7:0] m [32];
        logic [4:0] a;
        q_addr.delete(); q_we.delete(); q_di.delete();
        m_cnt = 0; m_mask = 8'd0; m_faddr = 5'd0; m_fvalid = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 8'd0;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            q_addr.push_back(a); q_we.push_back(1'b1); q_di.push_back(BG);
            m[map_addr(a, alias_en)] = BG;
        end
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            q_addr.push_back(a); q_we.push_back(1'b0); q_di.push_back(8'd0);
            model_cmp(a, rd_fault(m[map_addr(a, alias_en)], a, stuck_en, stuck_addr, stuck_bit, stuck_val), BG);
            q_addr.push_back(a); q_we.push_back(1'b1); q_di.push_back(~BG);
            m[map_addr(a, alias_en)] = ~BG;
        end
        for (int i = 31; i >= 0; i--) begin
            a = 5'(i);
            q_addr.push_back(a); q_we.push_back(1'b0); q_di.push_back(8'd0);
            model_cmp(a, rd_fault(m[map_addr(a, alias_en)], a, stuck_en, stuck_addr, stuck_bit, stuck_val), ~BG);
        end
    endtask

    // Pulses start from IDLE/DONE, checks all 128 run cycles and the DONE diagnostics.
    // p0/p1 are run cycles at which an extra (to-be-ignored) start pulse is driven.
    task automatic run_march(input string name, input int p0, input int p1);
        model_run();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        checks++;
        if (bus.err_count !== 7'd0 || bus.err_mask !== 8'd0 || bus.first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s clear_on_start: cnt=%0d mask=%h fv=%b want 0/00/0",
                     name, bus.err_count, bus.err_mask, bus.first_err_valid);
        end
        for (int c = 0; c < 128; c++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dram_addr !== q_addr[c] ||
                bus.dram_we !== q_we[c] || (q_we[c] && bus.dram_di !== q_di[c])) begin
                errors++;
                $display("FAIL %s cycle %0d: busy=%b done=%b addr=%0d we=%b di=%h want busy=1 done=0 addr=%0d we=%b di=%h",
                         name, c, bus.busy, bus.done, bus.dram_addr, bus.dram_we, bus.dram_di,
                         q_addr[c], q_we[c], q_di[c]);
            end
            bus.start = (c == p0 || c == p1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pass !== (m_cnt == 0)) begin
            errors++;
            $display("FAIL %s done_at_128: done=%b busy=%b pass=%b want 1/0/%b",
                     name, bus.done, bus.busy, bus.pass, (m_cnt == 0));
        end
        checks++;
        if (bus.err_count !== 7'(m_cnt) || bus.err_mask !== m_mask ||
            bus.first_err_valid !== m_fvalid || bus.first_err_addr !== m_faddr) begin
            errors++;
            $display("FAIL %s diag: cnt=%0d mask=%h fv=%b fa=%0d want cnt=%0d mask=%h fv=%b fa=%0d",
                     name, bus.err_count, bus.err_mask, bus.first_err_valid, bus.first_err_addr,
                     m_cnt, m_mask, m_fvalid, m_faddr);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (bus.dram_we !== 1'b0 || bus.dram_addr !== 5'd0 || bus.dram_di !== 8'd0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
            bus.err_count !== 7'd0 || bus.err_mask !== 8'd0 ||
            bus.first_err_addr !== 5'd0 || bus.first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: we=%b addr=%0d di=%h busy=%b done=%b pass=%b cnt=%0d mask=%h fa=%0d fv=%b want all zero",
                     name, bus.dram_we, bus.dram_addr, bus.dram_di, bus.busy, bus.done, bus.pass,
                     bus.err_count, bus.err_mask, bus.first_err_addr, bus.first_err_valid);
        end
    endtask

    task automatic set_fault_free();
        alias_en = 1'b0; stuck_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("idle_after_release");
    endtask

    task automatic test_fault_free();
        set_fault_free();
        run_march("fault_free", -1, -1);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (mem[i] !== ~BG) begin
                errors++;
                $display("FAIL ram_contents addr %0d: got %h want %h", i, mem[i], ~BG);
            end
        end
    endtask

    task automatic test_stuck_bit();
        set_fault_free();
        stuck_en = 1'b1; stuck_addr = 5'd7; stuck_bit = 3'd3; stuck_val = 1'b0;
        run_march("stuck_bit3_addr7", -1, -1);
        checks++;
        if (bus.err_count !== 7'd1 || bus.err_mask !== 8'h08 || bus.first_err_addr !== 5'd7) begin
            errors++;
            $display("FAIL stuck_fixed: cnt=%0d mask=%h fa=%0d want 1/08/7",
                     bus.err_count, bus.err_mask, bus.first_err_addr);
        end
    endtask

    task automatic test_restart_clears();
        set_fault_free();
        run_march("restart_after_fail", -1, -1);
    endtask

    task automatic test_alias();
        set_fault_free();
        alias_en = 1'b1;
        run_march("alias_a4", -1, -1);
        checks++;
        if (bus.err_count !== 7'd16 || bus.err_mask !== 8'hFF || bus.first_err_addr !== 5'd16) begin
            errors++;
            $display("FAIL alias_fixed: cnt=%0d mask=%h fa=%0d want 16/ff/16",
                     bus.err_count, bus.err_mask, bus.first_err_addr);
        end
    endtask

    task automatic test_ignored_start();
        set_fault_free();
        run_march("ignored_start", 10, 96 + 5);
    endtask

    task automatic test_reset_midrun();
        set_fault_free();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        // cycle 51 is a W1 write, so the asynchronous drop of the write enable is observable
        repeat (51) @(negedge clk);
        checks++;
        if (bus.dram_we !== 1'b1) begin
            errors++;
            $display("FAIL midrun_we_before_rst: got %b want 1", bus.dram_we);
        end
        #1 rst = 1'b1;
        #1 check_reset_values("async_reset_midrun");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_march("clean_after_reset", -1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            set_fault_free();
            stuck_en   = 1'($urandom_range(0, 1));
            stuck_addr = 5'($urandom_range(0, 31));
            stuck_bit  = 3'($urandom_range(0, 7));
            stuck_val  = 1'($urandom_range(0, 1));
            alias_en   = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_march($sformatf("random_%0d", k), -1, -1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_bit();
        test_restart_clears();
        test_alias();
        test_ignored_start();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
